// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - address generation and sequencing for the in-place radix-2 DIT FFT
// Optional feature macro: AGU_LOAD_EN (bit-reversed sample load phase ahead of RUN)
module fft_agu #(
    parameter int N      = 9,
    parameter int BF_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef AGU_LOAD_EN
    input  logic                 sample_valid,
    output logic                 load_phase,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 we,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic [N-2:0]         tw_add,
    output logic [$clog2(N)-1:0] stage
);

    localparam int SW = $clog2(N);
    localparam int PW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;

    localparam logic [PW-1:0]  P_LAST = PW'(BF_LAT);
    localparam logic [N-2:0]   I_LAST = {(N-1){1'b1}};
    localparam logic [SW-1:0]  S_LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [N-2:0]  i_q, i_d;
    logic [PW-1:0] p_q, p_d;

    // Butterfly address terms derived from the registered stage/index
    logic [N-2:0]  mask;
    logic [N-2:0]  low;
    logic [N-2:0]  high;
    logic [N-1:0]  run_a;
    logic [N-1:0]  run_b;
    logic [N-2:0]  run_tw;

`ifdef AGU_LOAD_EN
    logic [N-1:0]  load_q, load_d;
    logic [N-1:0]  load_rev;
`endif

    // State and counter registers; reset aborts any transform immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            i_q     <= '0;
            p_q     <= '0;
`ifdef AGU_LOAD_EN
            load_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            i_q     <= i_d;
            p_q     <= p_d;
`ifdef AGU_LOAD_EN
            load_q  <= load_d;
`endif
        end
    end

    // Address arithmetic: insert a zero at bit s of i to get the upper leg
    always_comb begin
        mask   = ~({(N-1){1'b1}} << s_q);
        low    = i_q & mask;
        high   = i_q & ~mask;
        run_a  = {high, 1'b0} | {1'b0, low};
        run_b  = run_a | (N'(1) << s_q);
        run_tw = low << (N - 1 - int'(s_q));
`ifdef AGU_LOAD_EN
        load_rev = '0;
        for (int j = 0; j < N; j++) begin
            load_rev[j] = load_q[N-1-j];
        end
`endif
    end

    // Next-state, counter advance and output decode
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        i_d     = i_q;
        p_d     = p_q;
        busy    = 1'b0;
        done    = 1'b0;
        we      = 1'b0;
        add_a   = '0;
        add_b   = '0;
        tw_add  = '0;
        stage   = '0;
`ifdef AGU_LOAD_EN
        load_d     = load_q;
        load_phase = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d = '0;
                    i_d = '0;
                    p_d = '0;
`ifdef AGU_LOAD_EN
                    load_d  = '0;
                    state_d = LOAD;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                busy   = 1'b1;
                add_a  = run_a;
                add_b  = run_b;
                tw_add = run_tw;
                stage  = s_q;
                if (p_q == P_LAST) begin
                    // Result is ready: write back in place and move on
                    we  = 1'b1;
                    p_d = '0;
                    if (i_q == I_LAST) begin
                        i_d = '0;
                        if (s_q == S_LAST) begin
                            s_d     = '0;
                            state_d = DONE_S;
                        end else begin
                            s_d = s_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            DONE_S: begin
                done    = 1'b1;
                state_d = IDLE;
            end
`ifdef AGU_LOAD_EN
            LOAD: begin
                busy       = 1'b1;
                load_phase = 1'b1;
                if (sample_valid) begin
                    we     = 1'b1;
                    add_a  = load_rev;
                    add_b  = load_rev;
                    load_d = load_q + 1'b1;
                    if (load_q == {N{1'b1}}) begin
                        load_d  = '0;
                        state_d = RUN;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_agu.sv
// tb/tb_fft_agu.sv - scoreboard bench for fft_agu against a stage/butterfly enumeration model
module tb_fft_agu;

    localparam int N      = 3;
    localparam int BF_LAT = 1;
    localparam int PTS    = 1 << N;
    localparam int SW     = $clog2(N);
`ifdef AGU_LOAD_EN
    localparam int LOADN  = PTS;
`else
    localparam int LOADN  = 0;
`endif
    localparam int BUSY   = LOADN + N * (PTS / 2) * (BF_LAT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, we;
    logic [N-1:0]  add_a, add_b;
    logic [N-2:0]  tw_add;
    logic [SW-1:0] stage;
`ifdef AGU_LOAD_EN
    logic          sample_valid = 1'b1;
    logic          load_phase;
`else
    logic          load_phase = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          we;
        logic          lp;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [N-2:0]  tw;
        logic [SW-1:0] st;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    fft_agu #(.N(N), .BF_LAT(BF_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
`ifdef AGU_LOAD_EN
        .sample_valid (sample_valid),
        .load_phase   (load_phase),
`endif
        .busy         (busy),
        .done         (done),
        .we           (we),
        .add_a        (add_a),
        .add_b        (add_b),
        .tw_add       (tw_add),
        .stage        (stage)
    );

    always #5 clk = ~clk;

    // Expected per-cycle output of one transform, truncated after cut records (cut<0: whole run plus done)
    task automatic push_xform(input int cut);
        rec_t r;
        int   n = 0;
`ifdef AGU_LOAD_EN
        for (int k = 0; k < PTS; k++) begin
            int v = k;
            int rv = 0;
            for (int j = 0; j < N; j++) begin
                rv = rv * 2 + v % 2;
                v  = v / 2;
            end
            r = '0;
            r.busy = 1'b1; r.lp = 1'b1; r.we = 1'b1;
            r.a = N'(rv); r.b = N'(rv);
            if (cut < 0 || n < cut) exp_q.push_back(r);
            n++;
        end
`endif
        for (int s = 0; s < N; s++) begin
            for (int a = 0; a < PTS; a++) begin
                if ((a / (2 ** s)) % 2 == 0) begin
                    for (int p = 0; p <= BF_LAT; p++) begin
                        r = '0;
                        r.busy = 1'b1;
                        r.we   = (p == BF_LAT);
                        r.a    = N'(a);
                        r.b    = N'(a + 2 ** s);
                        r.tw   = (N-1)'((a % (2 ** s)) * (2 ** (N - 1 - s)));
                        r.st   = SW'(s);
                        if (cut < 0 || n < cut) exp_q.push_back(r);
                        n++;
                    end
                end
            end
        end
        if (cut < 0) begin
            r = '0;
            r.done = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    task automatic check(input rec_t got, input rec_t e);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL outputs cyc=%0d got busy=%b done=%b we=%b lp=%b a=%0d b=%0d tw=%0d st=%0d need busy=%b done=%b we=%b lp=%b a=%0d b=%0d tw=%0d st=%0d",
                     cyc, got.busy, got.done, got.we, got.lp, got.a, got.b, got.tw, got.st,
                     e.busy, e.done, e.we, e.lp, e.a, e.b, e.tw, e.st);
        end
    endtask

    // Monitor: every cycle pop the next expected record, or expect all-zero outputs when none is pending
    initial begin
        rec_t got;
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                got = {busy, done, we, load_phase, add_a, add_b, tw_add, stage};
                e = '0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                check(got, e);
            end
        end
    end

    initial begin
        rec_t idle_r;
        idle_r = '0;

        // Reset held two cycles with start high: nothing must begin
        start = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Single start pulse: full sequence and done pulse
        start = 1'b1;
        push_xform(-1);
        @(negedge clk);
        start = 1'b0;
        repeat (BUSY + 2 + $urandom_range(0, 3)) @(negedge clk);

        // Random start activity during RUN and DONE is ignored
        start = 1'b1;
        push_xform(-1);
        @(negedge clk);
        for (int k = 1; k <= BUSY + 1; k++) begin
            start = 1'($urandom % 2);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3 + $urandom_range(0, 3)) @(negedge clk);

        // Start held high: one idle cycle after done, then a second transform
        start = 1'b1;
        push_xform(-1);
        exp_q.push_back(idle_r);
        push_xform(-1);
        repeat (BUSY + 6) @(negedge clk);
        start = 1'b0;
        repeat (BUSY + 4) @(negedge clk);

        // Reset while at stage 1, i=2, then a clean restart
        start = 1'b1;
        push_xform(LOADN + 13);
        @(negedge clk);
        start = 1'b0;
        repeat (LOADN + 12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        push_xform(-1);
        @(negedge clk);
        start = 1'b0;
        repeat (BUSY + 5) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending records need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_agu.md
Name: fft_agu

Overview:
- Address-generation and sequencing controller for the in-place radix-2 DIT FFT.
- Drives the two-port butterfly RAM (shared read/write addresses `add_a`/`add_b`, single `we`, combinational read) and supplies the twiddle ROM address.
- Steps through all N stages × 2^(N-1) butterflies, holding each address pair until the butterfly result is ready, then pulses `we` so the result is written back in place.
- Sits between the top-level FFT control and the RAM/butterfly datapath.

Parameters:
- N, 9, log2 of FFT size (2^N points; matches RAM address width).
- BF_LAT, 1, register stages in the butterfly from RAM dout to result valid (0 = combinational).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse when the transform completes.
- we  out  1  RAM write enable; both ports written when high.
- add_a  out  N  RAM port-A address (upper butterfly leg).
- add_b  out  N  RAM port-B address (lower butterfly leg).
- tw_add  out  N-1  twiddle ROM address.
- stage  out  $clog2(N)  current stage index, 0..N-1.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE and all counters 0. `busy`, `done`, `we`, `add_a`, `add_b`, `tw_add`, `stage` are all 0.
- States: IDLE → RUN → DONE → IDLE.
  - IDLE: `start`=1 at an edge → RUN at the next cycle with s=0, i=0, phase=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1 for exactly one cycle, then IDLE.
- Counters: stage s (0..N-1), butterfly i (0..2^(N-1)-1), phase p (0..BF_LAT).
- Addresses (combinational from the registered s and i; valid while in RUN):
  - low = i & (2^s − 1)
  - add_a = ((i >> s) << (s+1)) | low
  - add_b = add_a | 2^s
  - tw_add = low << (N−1−s)
- Addresses are held for BF_LAT+1 cycles per butterfly.
- `we`=1 only when p==BF_LAT. The write uses the same `add_a`/`add_b` the read used (read old, write new in place).
- Counter advance:
  - p increments each cycle and wraps to 0 at BF_LAT.
  - On wrap, i increments.
  - When i wraps from 2^(N-1)−1, s increments.
  - A write with s==N−1 and i==2^(N-1)−1 → DONE.
- Latency: `busy` is high for exactly N·2^(N-1)·(BF_LAT+1) cycles; `done` is asserted in the following cycle.
- Stage hazard: none. The next stage's first read happens after the previous stage's last write edge.
- `start` while `busy` or in DONE: ignored, no restart.
- `start` held high: a new transform begins one cycle after `done`, since IDLE is occupied for one cycle.
- Reset mid-operation: abort immediately and return to reset values. No partial write occurs after the reset edge.
- Outside RUN: `add_a`, `add_b`, `tw_add` and `stage` are driven to 0, and `we`=0.

Optional Feature:
- Macro: `AGU_LOAD_EN`.
- When defined:
  - Adds input `sample_valid` (1) and output `load_phase` (1).
  - `start` enters state LOAD instead of RUN.
  - In LOAD, `load_phase`=1 and `busy`=1. Each cycle with `sample_valid`=1 gives `we`=1 and add_a = add_b = bit-reverse(load_cnt), then load_cnt increments.
  - After 2^N accepted samples → RUN with counters 0.
  - `sample_valid`=0 stalls with `we`=0. `load_phase` drives the external din mux.
- When undefined: neither port exists; behaviour is exactly as above.

Test Plan:
- Reset check: assert `reset` for 2 cycles → all outputs 0, state IDLE; `start` during `reset` is ignored.
- Address sequence, N=3, BF_LAT=0, pulse `start` → `busy` high exactly 12 cycles.
  - Stage 0 pairs (0,1) (2,3) (4,5) (6,7), tw 0.
  - Stage 1 pairs (0,2) (1,3) (4,6) (5,7), tw 0,2,0,2.
  - Stage 2 pairs (0,4) (1,5) (2,6) (3,7), tw 0,1,2,3.
  - `we`=1 every cycle; `done` pulses in cycle 13.
- Latency, N=3, BF_LAT=1 → `busy` high 24 cycles; `we` high on alternate cycles; each address pair held 2 cycles; `done` width 1.
- Simultaneous/ignored start: `start` pulses mid-transform → sequence and cycle count unchanged. `start` held high continuously → second transform starts one cycle after the `done` pulse.
- Reset mid-operation: `reset` at stage 1, i=2 → next cycle `busy`=0, `we`=0, addresses 0; a fresh `start` restarts from stage 0, i=0.
- `AGU_LOAD_EN`, N=3: feed 8 samples with `sample_valid` dropped for 2 cycles mid-stream → write addresses 0,4,2,6,1,5,3,7; `we`=0 during the gap; RUN begins the cycle after the 8th sample.
